// File: rtl/seven_seg_scanner_if.sv
// Display-value / segment-pin bus for seven_seg_scanner.
// master: display-value logic (drives codes, dp, enables, lz; sees pins).
// slave : the scanner itself.
interface seven_seg_scanner_if #(
  parameter int NUM_DIGITS = 6
);
  localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_suppress;
  logic [SEL_W-1:0]        mux_sel;
  logic [3:0]              data_out;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    frame_done;

  modport master (
    output data_in, dp_in, digit_en, lz_suppress,
    input  mux_sel, data_out, seg_n, dp_n, an_n, frame_done
  );

  modport slave (
    input  data_in, dp_in, digit_en, lz_suppress,
    output mux_sel, data_out, seg_n, dp_n, an_n, frame_done
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with prescaled digit
// slots, dead-time anti-ghosting, frame-latched (tear-free) shadow inputs,
// leading-zero suppression, per-digit enable and decimal point.
module seven_seg_scanner #(
  parameter int NUM_DIGITS  = 6,
  parameter int PRESCALE    = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input logic                clk,
  input logic                rst_n,
  seven_seg_scanner_if.slave bus
);
  localparam int          SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int          CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned ND    = NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
  localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(NUM_DIGITS - 1);

  // ST_PRIME: first clock after reset release loads the shadow without a frame pulse
  typedef enum logic {ST_PRIME, ST_RUN} state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [SEL_W-1:0]        r_sel;
  logic [4*NUM_DIGITS-1:0] r_code;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_en;
  logic                    r_lz;
  logic [3:0]              r_data_out;
  logic [6:0]              r_seg_n;
  logic                    r_dp_n;
  logic [NUM_DIGITS-1:0]   r_an_n;
  logic                    r_frame_done;

  logic                    w_tick;
  logic                    w_wrap;
  logic                    w_load;
  logic [3:0]              w_code;
  logic                    w_dp;
  logic                    w_en;
  logic                    w_hi_zero;
  logic                    w_lz_blank;
  logic                    w_bad_code;
  logic                    w_blank;
  logic [6:0]              w_glyph;
  logic [6:0]              w_seg_n;
  logic [3:0]              w_data_out;
  logic                    w_dp_n;
  logic [NUM_DIGITS-1:0]   w_an_n;

  // Slot timing: end-of-slot tick, end-of-frame wrap, and shadow load strobe
  always_comb begin
    w_tick = (r_cnt == CNT_MAX);
    w_wrap = w_tick && (r_sel == SEL_MAX);
    w_load = w_wrap || (r_state == ST_PRIME);
  end

  // Select the current digit from the shadow and work out its pin pattern
  always_comb begin
    w_code    = 4'h0;
    w_dp      = 1'b0;
    w_en      = 1'b0;
    w_hi_zero = 1'b1;
    for (int unsigned i = 0; i < ND; i++) begin
      if (r_sel == SEL_W'(i)) begin
        w_code = r_code[4*i +: 4];
        w_dp   = r_dp[i];
        w_en   = r_en[i];
      end
      // digits from the current one up to the most significant must all be zero
      if ((SEL_W'(i) >= r_sel) && (r_code[4*i +: 4] != 4'h0))
        w_hi_zero = 1'b0;
    end
    w_lz_blank = r_lz && (r_sel != '0) && w_hi_zero;
    w_bad_code = (w_code > 4'h9) && (w_code != 4'hB);
    w_blank    = !w_en || w_lz_blank || w_bad_code;

    case (w_code)
      4'h0:    w_glyph = 7'b1000000;
      4'h1:    w_glyph = 7'b1111001;
      4'h2:    w_glyph = 7'b0100100;
      4'h3:    w_glyph = 7'b0110000;
      4'h4:    w_glyph = 7'b0011001;
      4'h5:    w_glyph = 7'b0010010;
      4'h6:    w_glyph = 7'b0000010;
      4'h7:    w_glyph = 7'b1111000;
      4'h8:    w_glyph = 7'b0000000;
      4'h9:    w_glyph = 7'b0010000;
      4'hB:    w_glyph = 7'b0111111;
      default: w_glyph = 7'h7F;
    endcase

    w_seg_n    = w_blank ? 7'h7F : w_glyph;
    w_data_out = w_blank ? 4'hA : w_code;
    w_dp_n     = w_blank ? 1'b1 : ~w_dp;

    w_an_n = '1;
    for (int unsigned i = 0; i < ND; i++) begin
      if (!w_blank && (r_cnt >= CNT_DEAD) && (r_sel == SEL_W'(i)))
        w_an_n[i] = 1'b0;
    end
  end

  // Prescaler, slot sequencing, shadow capture and registered pin outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_PRIME;
      r_cnt        <= '0;
      r_sel        <= '0;
      r_code       <= '0;
      r_dp         <= '0;
      r_en         <= '0;
      r_lz         <= 1'b0;
      r_data_out   <= 4'hA;
      r_seg_n      <= 7'h7F;
      r_dp_n       <= 1'b1;
      r_an_n       <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_state <= ST_RUN;
      r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick)
        r_sel <= w_wrap ? '0 : r_sel + 1'b1;
      if (w_load) begin
        r_code <= bus.data_in;
        r_dp   <= bus.dp_in;
        r_en   <= bus.digit_en;
        r_lz   <= bus.lz_suppress;
      end
      r_frame_done <= w_wrap;
      r_data_out   <= w_data_out;
      r_seg_n      <= w_seg_n;
      r_dp_n       <= w_dp_n;
      r_an_n       <= w_an_n;
    end
  end

  assign bus.mux_sel    = r_sel;
  assign bus.data_out   = r_data_out;
  assign bus.seg_n      = r_seg_n;
  assign bus.dp_n       = r_dp_n;
  assign bus.an_n       = r_an_n;
  assign bus.frame_done = r_frame_done;
endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Time-multiplexed driver for a common-anode multi-digit seven-segment display.
- Autonomously scans NUM_DIGITS BCD/code nibbles and decodes each to segments.
- Features: programmable refresh prescaler, anti-ghosting dead time, tear-free frame buffering, leading-zero suppression, per-digit enable and decimal-point control.
- Sits between the machine's display-value logic (credit/price nibbles) and the board pins.

Parameters:
- NUM_DIGITS, 6, number of digits scanned; legal range 1..8.
- PRESCALE, 50000, clock cycles per digit slot; minimum 2.
- DEAD_CYCLES, 500, cycles at the start of each slot with all anodes off; must be less than PRESCALE.
- SEL_W, derived as max(1, clog2(NUM_DIGITS)); width of mux_sel.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  4*NUM_DIGITS  packed digit codes; digit i is data_in[4i+3:4i]; digit 0 is least significant (rightmost).
- dp_in  in  NUM_DIGITS  decimal point request per digit, active high.
- digit_en  in  NUM_DIGITS  per-digit enable; 0 forces that digit blank.
- lz_suppress  in  1  1 = blank leading zeros.
- mux_sel  out  SEL_W  index of the digit currently being scanned.
- data_out  out  4  code of the displayed digit; 4'hA when blanked.
- seg_n  out  7  active-low segments, ordered {g,f,e,d,c,b,a}.
- dp_n  out  1  active-low decimal point.
- an_n  out  NUM_DIGITS  active-low anode enables, one-hot-low or all ones.
- frame_done  out  1  one-cycle pulse when a new frame starts.

Behaviour:
- Reset (async, rst_n=0):
  - prescaler count=0, mux_sel=0, shadow buffers (code, dp, enable, lz)=0.
  - an_n=all ones, seg_n=7'h7F, dp_n=1, data_out=4'hA, frame_done=0.
  - Internal prime flag set; all outputs take these values immediately, independent of clk.
- Prescaler:
  - cnt counts 0..PRESCALE-1.
  - tick asserts when cnt==PRESCALE-1; cnt then returns to 0.
- Slot sequencing:
  - On tick, mux_sel increments.
  - At NUM_DIGITS-1, mux_sel wraps to 0 instead (never reaches values >= NUM_DIGITS).
- Shadow load (tear-free):
  - data_in, dp_in, digit_en and lz_suppress are captured into the shadow buffers on the wrap edge, and on the first clock after reset release (clears prime).
  - Input changes at any other time have no visible effect until the next wrap.
- frame_done:
  - Registered; high for exactly one cycle, in the cycle after each wrap edge.
  - Not asserted for the post-reset prime load.
- Leading-zero suppression (computed on shadow):
  - When lz=1, digit i is blanked if i>0 and shadow codes of digits NUM_DIGITS-1..i are all 0.
  - Digit 0 is never suppressed, so an all-zero value shows a single "0".
- Blank condition for the current digit: shadow enable=0, OR leading-zero suppressed, OR code in {4'hA, 4'hC..4'hF}.
- Decode: 0-9 standard glyphs; 4'hB = minus (segment g only, seg_n=7'b0111111); all others blank.
  - 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 4=7'b0011001
  - 5=7'b0010010, 6=7'b0000010, 7=7'b1111000, 8=7'b0000000, 9=7'b0010000
- Outputs:
  - All registered, one cycle behind mux_sel/cnt/shadow.
  - For a blanked digit: seg_n=7'h7F, dp_n=1, data_out=4'hA, anode held off.
  - For a non-blanked digit: an_n has bit mux_sel low only when cnt>=DEAD_CYCLES; all anodes are off while cnt<DEAD_CYCLES.
  - dp_n = ~shadow dp for a non-blanked digit; a dp request on a blanked digit is ignored.
- NUM_DIGITS=1: mux_sel stays 0; a wrap occurs on every tick.
- Reset asserted mid-slot or mid-frame: immediate return to reset values. The scan restarts at digit 0 with a full PRESCALE-cycle slot.

Test Plan:
- Bench setting for all scenarios: NUM_DIGITS=4, PRESCALE=4, DEAD_CYCLES=1.
- Reset: hold rst_n=0 with data_in toggling -> an_n=4'hF, seg_n=7'h7F, dp_n=1, data_out=4'hA, mux_sel=0, frame_done=0 throughout.
- Basic scan: data_in=16'h4321, digit_en=4'hF, lz=0 -> mux_sel runs 0,1,2,3,0 at 4 cycles per slot. Per slot: an_n=4'hF for 1 cycle, then 3 cycles with the selected bit low. Slot 0 shows seg_n=7'b1111001, data_out=1; slot 3 shows 7'b0011001, data_out=4. frame_done pulses once every 16 cycles.
- Tear-free: change data_in from 16'h4321 to 16'h9999 during slot 1 -> slots 1-3 still show 2,3,4; the next frame shows 9 on all digits.
- Leading zeros: data_in=16'h0050, lz=1 -> digits 3,2 keep anodes off with data_out=4'hA; digit 1 shows 5; digit 0 shows 0. data_in=16'h0000 -> only digit 0 lit, showing "0".
- Mask/dp/minus: data_in=16'hB012, digit_en=4'b1101, dp_in=4'b0110, lz=0 -> digit 0 = 2 with dp_n=1; digit 1 blank with dp_n=1 (dp ignored); digit 2 = 0 with dp_n=0; digit 3 = minus, seg_n=7'b0111111.
- Async reset mid-slot: assert rst_n=0 while cnt=2 of slot 2 -> outputs reach reset values before the next clk edge. After release: prime reload, slot 0 lasts a full 4 cycles, and no frame_done for the prime load.
